// File: rtl/bad_latch.sv
// bad_latch: flop-based, glitch-free stand-in for a level-sensitive data latch.
// An optional synchroniser samples a possibly asynchronous `d`. The result is
// held on `q` and updates only on rising clk edges. The block also reports the
// previous value, a change pulse and a saturating change counter.
// Every output comes straight from a flop. Reset is synchronous and active-low.

module bad_latch #(
    parameter int               WIDTH       = 1,
    parameter int               SYNC_STAGES = 2,   // 0..4, 0 = no synchroniser
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   q_prev,
    output logic               q_changed,
    output logic [COUNT_W-1:0] chg_count
);

    // The value presented to the holding register on the next edge.
    logic [WIDTH-1:0] sampled;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sampled = d;
        end else begin : g_sync
            logic [WIDTH-1:0] stage [SYNC_STAGES];

            // Shift d through the synchroniser chain; reset flushes any value in flight.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    // NOTE: every synchroniser stage is reset, not just q. A value caught
                    // before reset must not emerge on q after release.
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    // NOTE: non-blocking assignments make each stage take the old value
                    // of the one before it, so the chain shifts one step per edge.
                    stage[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign sampled = stage[SYNC_STAGES-1];
        end
    endgenerate

    // The new value differs from the held one, so q changes on this edge.
    logic changing;
    assign changing = (sampled != q);

    // Holding register plus observability state, all updated only on rising clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q         <= RESET_VAL;
            q_prev    <= RESET_VAL;
            q_changed <= 1'b0;
            chg_count <= '0;
        end else begin
            q         <= sampled;
            q_prev    <= q;
            q_changed <= changing;
            // Saturate at all-ones rather than wrapping back to zero.
            if (changing && (chg_count != '1)) begin
                chg_count <= chg_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bad_latch.sv
// Directed testbench for bad_latch. There are three instances:
//   dut_def : default parameters (two-stage synchroniser, 8-bit counter)
//   dut_s0  : SYNC_STAGES = 0 (plain D flop) for async-toggle and glitch tests
//   dut_sat : SYNC_STAGES = 0, COUNT_W = 2 for counter saturation
// The clock period is 40 ns. Outputs are sampled 1 ns after each rising edge.
// Inputs are driven at that same point, well before the next edge.

module tb_bad_latch;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default instance
    logic       rst_def = 1'b0;
    logic [0:0] d_def = 1'b0;
    logic [0:0] q_def, qp_def;
    logic       qc_def;
    logic [7:0] cnt_def;

    // SYNC_STAGES = 0 instance
    logic       rst_s0 = 1'b0;
    logic [0:0] d_s0 = 1'b0;
    logic [0:0] q_s0, qp_s0;
    logic       qc_s0;
    logic [7:0] cnt_s0;

    // Saturation instance
    logic       rst_sat = 1'b0;
    logic [0:0] d_sat = 1'b0;
    logic [0:0] q_sat, qp_sat;
    logic       qc_sat;
    logic [1:0] cnt_sat;

    bad_latch dut_def (
        .clk(clk), .reset(rst_def), .d(d_def),
        .q(q_def), .q_prev(qp_def), .q_changed(qc_def), .chg_count(cnt_def)
    );

    bad_latch #(.SYNC_STAGES(0)) dut_s0 (
        .clk(clk), .reset(rst_s0), .d(d_s0),
        .q(q_s0), .q_prev(qp_s0), .q_changed(qc_s0), .chg_count(cnt_s0)
    );

    bad_latch #(.SYNC_STAGES(0), .COUNT_W(2)) dut_sat (
        .clk(clk), .reset(rst_sat), .d(d_sat),
        .q(q_sat), .q_prev(qp_sat), .q_changed(qc_sat), .chg_count(cnt_sat)
    );

    // Model state for the SYNC_STAGES = 0 instance, shared by the async and glitch tests
    logic [0:0] m_q;
    logic [0:0] m_prev;
    logic       m_chg;
    int         m_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default instance checked against its reset values over 3 edges while d toggles.
    task automatic test_reset();
        rst_def = 1'b0;
        rst_s0  = 1'b0;
        rst_sat = 1'b0;
        for (int e = 0; e < 3; e++) begin
            d_def = ~d_def;
            d_s0  = ~d_s0;
            d_sat = ~d_sat;
            tick();
            n_cmp++; if (q_def !== 1'b0)  begin n_err++; $display("FAIL reset_q edge%0d: got %b want 0", e, q_def); end
            n_cmp++; if (qp_def !== 1'b0) begin n_err++; $display("FAIL reset_q_prev edge%0d: got %b want 0", e, qp_def); end
            n_cmp++; if (qc_def !== 1'b0) begin n_err++; $display("FAIL reset_q_changed edge%0d: got %b want 0", e, qc_def); end
            n_cmp++; if (cnt_def !== 8'd0) begin n_err++; $display("FAIL reset_count edge%0d: got %0d want 0", e, cnt_def); end
        end
    endtask

    // A 1 on d before the first edge after release reaches q at edge 3.
    task automatic test_latency();
        rst_def = 1'b1;
        d_def   = 1'b1;
        tick();  // edge 1
        n_cmp++; if (q_def !== 1'b0) begin n_err++; $display("FAIL latency_e1_q: got %b want 0", q_def); end
        n_cmp++; if (qc_def !== 1'b0) begin n_err++; $display("FAIL latency_e1_chg: got %b want 0", qc_def); end
        tick();  // edge 2
        n_cmp++; if (q_def !== 1'b0) begin n_err++; $display("FAIL latency_e2_q: got %b want 0", q_def); end
        tick();  // edge 3
        n_cmp++; if (q_def !== 1'b1) begin n_err++; $display("FAIL latency_e3_q: got %b want 1", q_def); end
        n_cmp++; if (qp_def !== 1'b0) begin n_err++; $display("FAIL latency_e3_q_prev: got %b want 0", qp_def); end
        n_cmp++; if (qc_def !== 1'b1) begin n_err++; $display("FAIL latency_e3_chg: got %b want 1", qc_def); end
        n_cmp++; if (cnt_def !== 8'd1) begin n_err++; $display("FAIL latency_e3_count: got %0d want 1", cnt_def); end
        tick();  // edge 4: the pulse lasts exactly one cycle
        n_cmp++; if (q_def !== 1'b1) begin n_err++; $display("FAIL latency_e4_q: got %b want 1", q_def); end
        n_cmp++; if (qp_def !== 1'b1) begin n_err++; $display("FAIL latency_e4_q_prev: got %b want 1", qp_def); end
        n_cmp++; if (qc_def !== 1'b0) begin n_err++; $display("FAIL latency_e4_chg: got %b want 0", qc_def); end
        n_cmp++; if (cnt_def !== 8'd1) begin n_err++; $display("FAIL latency_e4_count: got %0d want 1", cnt_def); end
    endtask

    // A 1 caught in the synchroniser is discarded by reset and never reaches q.
    task automatic test_reset_mid();
        rst_def = 1'b0;
        d_def   = 1'b0;
        tick();
        rst_def = 1'b1;
        repeat (3) tick();
        n_cmp++; if (q_def !== 1'b0) begin n_err++; $display("FAIL midrst_settle_q: got %b want 0", q_def); end
        d_def = 1'b1;
        tick();          // the 1 enters the first synchroniser stage
        rst_def = 1'b0;  // d remains 1 while reset is sampled
        tick();
        rst_def = 1'b1;
        d_def   = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            n_cmp++; if (q_def !== 1'b0) begin n_err++; $display("FAIL midrst_q edge%0d: got %b want 0", e, q_def); end
            n_cmp++; if (qc_def !== 1'b0) begin n_err++; $display("FAIL midrst_chg edge%0d: got %b want 0", e, qc_def); end
            n_cmp++; if (cnt_def !== 8'd0) begin n_err++; $display("FAIL midrst_count edge%0d: got %0d want 0", e, cnt_def); end
        end
    endtask

    // SYNC_STAGES = 0: d toggles every 23 ns against a 40 ns clock.
    // q follows d as sampled at each edge and stays constant between edges.
    task automatic test_async_toggle();
        rst_s0 = 1'b1;
        d_s0   = 1'b0;
        tick();
        m_q = 1'b0; m_prev = 1'b0; m_chg = 1'b0; m_cnt = 0;
        n_cmp++; if (q_s0 !== 1'b0) begin n_err++; $display("FAIL async_start_q: got %b want 0", q_s0); end
        // Toggles fall at edge+1+23k, which never lands on an edge for k < 33.
        fork
            begin
                repeat (30) begin
                    #23 d_s0 = ~d_s0;
                end
            end
            begin
                for (int e = 0; e < 16; e++) begin
                    @(posedge clk);
                    m_prev = m_q;
                    m_chg  = (d_s0 != m_q);
                    if (m_chg) m_cnt++;
                    m_q    = d_s0;
                    #1;
                    n_cmp++; if (q_s0 !== m_q) begin n_err++; $display("FAIL async_q edge%0d: got %b want %b", e, q_s0, m_q); end
                    n_cmp++; if (qp_s0 !== m_prev) begin n_err++; $display("FAIL async_q_prev edge%0d: got %b want %b", e, qp_s0, m_prev); end
                    n_cmp++; if (qc_s0 !== m_chg) begin n_err++; $display("FAIL async_chg edge%0d: got %b want %b", e, qc_s0, m_chg); end
                    n_cmp++; if (cnt_s0 !== 8'(m_cnt)) begin n_err++; $display("FAIL async_count edge%0d: got %0d want %0d", e, cnt_s0, m_cnt); end
                    #36;
                    n_cmp++; if (q_s0 !== m_q) begin n_err++; $display("FAIL async_hold edge%0d: got %b want %b", e, q_s0, m_q); end
                end
            end
        join
    endtask

    // A 5 ns pulse between two edges must not reach q.
    task automatic test_glitch();
        d_s0 = 1'b0;
        tick();
        tick();
        if (m_q != 1'b0) m_cnt++;  // track the return to 0 if the last sample was 1
        n_cmp++; if (q_s0 !== 1'b0) begin n_err++; $display("FAIL glitch_pre_q: got %b want 0", q_s0); end
        n_cmp++; if (cnt_s0 !== 8'(m_cnt)) begin n_err++; $display("FAIL glitch_pre_count: got %0d want %0d", cnt_s0, m_cnt); end
        #10 d_s0 = 1'b1;
        #5  d_s0 = 1'b0;
        #5;
        n_cmp++; if (q_s0 !== 1'b0) begin n_err++; $display("FAIL glitch_mid_q: got %b want 0", q_s0); end
        for (int e = 0; e < 2; e++) begin
            tick();
            n_cmp++; if (q_s0 !== 1'b0) begin n_err++; $display("FAIL glitch_q edge%0d: got %b want 0", e, q_s0); end
            n_cmp++; if (qc_s0 !== 1'b0) begin n_err++; $display("FAIL glitch_chg edge%0d: got %b want 0", e, qc_s0); end
            n_cmp++; if (cnt_s0 !== 8'(m_cnt)) begin n_err++; $display("FAIL glitch_count edge%0d: got %0d want %0d", e, cnt_s0, m_cnt); end
        end
    endtask

    // COUNT_W = 2: five changes read 1, 2, 3, 3, 3.
    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        rst_sat = 1'b1;
        d_sat   = 1'b0;
        tick();
        n_cmp++; if (cnt_sat !== 2'd0) begin n_err++; $display("FAIL sat_start_count: got %0d want 0", cnt_sat); end
        for (int k = 0; k < 5; k++) begin
            d_sat = ~d_sat;
            tick();
            n_cmp++; if (q_sat !== d_sat) begin n_err++; $display("FAIL sat_q change%0d: got %b want %b", k, q_sat, d_sat); end
            n_cmp++; if (qc_sat !== 1'b1) begin n_err++; $display("FAIL sat_chg change%0d: got %b want 1", k, qc_sat); end
            n_cmp++; if (cnt_sat !== exp_cnt[k]) begin n_err++; $display("FAIL sat_count change%0d: got %0d want %0d", k, cnt_sat, exp_cnt[k]); end
        end
        tick();
        n_cmp++; if (cnt_sat !== 2'd3) begin n_err++; $display("FAIL sat_hold_count: got %0d want 3", cnt_sat); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_reset_mid();
        test_async_toggle();
        test_glitch();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: the bench must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
